// File: rtl/i2c_target_responder.sv
// i2c_target_responder: I2C target emulating a register-mapped sensor with pointer, auto-increment and write strobes.
module i2c_target_responder #(
  parameter logic [6:0] DEV_ADDR = 7'b100_1000,
  parameter int NUM_REGS = 8,
  parameter int AUTOINC_BIT = 7,
  localparam int PW = $clog2(NUM_REGS)
) (
  input  logic                    FSM_Clk,
  input  logic                    reset,
  input  logic                    scl_in,
  input  logic                    sda_in,
  output logic                    sda_oe,
  input  logic [8*NUM_REGS-1:0]   reg_data,
  output logic                    wr_valid,
  output logic [PW-1:0]           wr_addr,
  output logic [7:0]              wr_data,
  output logic                    busy,
  output logic                    rx_nack
);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;
  state_t state, state_d;
  logic [2:0] scl_sync, sda_sync;
  logic [2:0] bit_cnt, bit_cnt_d;
  logic [7:0] shreg, shreg_d, byte_in, rd_byte, wr_data_d;
  logic [PW-1:0] ptr, ptr_d, ptr_inc, wr_addr_d;
  logic rw, rw_d, autoinc, autoinc_d, sda_oe_d, busy_d, wr_valid_d, rx_nack_d;
  logic sda_s, scl_rise, scl_fall, start, stop, last;
  // stages [1:0] synchronise the pads, stage [2] is the edge-detect history
  always_ff @(posedge FSM_Clk) begin
    scl_sync <= {scl_sync[1:0], scl_in};
    sda_sync <= {sda_sync[1:0], sda_in};
  end
  assign sda_s    = sda_sync[1];
  assign scl_rise = scl_sync[1] & ~scl_sync[2];
  assign scl_fall = ~scl_sync[1] & scl_sync[2];
  assign start    = scl_sync[1] & ~sda_sync[1] & sda_sync[2];
  assign stop     = scl_sync[1] & sda_sync[1] & ~sda_sync[2];
  assign byte_in  = {shreg[6:0], sda_s};
  assign last     = &bit_cnt;
  assign rd_byte  = reg_data[{ptr, 3'b000} +: 8];
  assign ptr_inc  = ptr + PW'(autoinc);
  always_ff @(posedge FSM_Clk) begin
    if (reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      rw       <= 1'b0;
      ptr      <= '0;
      autoinc  <= 1'b0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      rx_nack  <= 1'b0;
    end else begin
      state    <= state_d;
      bit_cnt  <= bit_cnt_d;
      shreg    <= shreg_d;
      rw       <= rw_d;
      ptr      <= ptr_d;
      autoinc  <= autoinc_d;
      sda_oe   <= sda_oe_d;
      busy     <= busy_d;
      wr_valid <= wr_valid_d;
      wr_addr  <= wr_addr_d;
      wr_data  <= wr_data_d;
      rx_nack  <= rx_nack_d;
    end
  end
  always_comb begin
    state_d    = state;
    bit_cnt_d  = bit_cnt;
    shreg_d    = shreg;
    rw_d       = rw;
    ptr_d      = ptr;
    autoinc_d  = autoinc;
    sda_oe_d   = sda_oe;
    busy_d     = busy;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr;
    wr_data_d  = wr_data;
    rx_nack_d  = 1'b0;
    if (start) begin
      state_d   = ADDR;
      sda_oe_d  = 1'b0;
      bit_cnt_d = '0;
    end else if (stop) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (scl_rise) begin
      if (state == ADDR || state == PTR || state == WDATA) begin
        shreg_d   = byte_in;
        bit_cnt_d = bit_cnt + 3'd1;
      end
      case (state)
        ADDR: if (last) begin
          state_d = byte_in[7:1] == DEV_ADDR ? ADDR_ACK : IGNORE;
          busy_d  = byte_in[7:1] == DEV_ADDR;
          rw_d    = byte_in[0];
        end
        PTR: if (last) begin
          state_d   = PTR_ACK;
          ptr_d     = byte_in[PW-1:0];
          autoinc_d = byte_in[AUTOINC_BIT];
        end
        WDATA: if (last) begin
          state_d    = WDATA_ACK;
          wr_valid_d = 1'b1;
          wr_addr_d  = ptr;
          wr_data_d  = byte_in;
          ptr_d      = ptr_inc;
        end
        RDATA_ACK: if (sda_s) begin
          state_d   = IGNORE;
          rx_nack_d = 1'b1;
          sda_oe_d  = 1'b0;
        end else
          ptr_d = ptr_inc;
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state)
        // sda_oe doubles as the ACK phase flag: low on entry, high while the ACK is held
        ADDR_ACK, PTR_ACK, WDATA_ACK: if (!sda_oe)
          sda_oe_d = 1'b1;
        else begin
          bit_cnt_d = '0;
          sda_oe_d  = 1'b0;
          state_d   = state != ADDR_ACK ? WDATA : rw ? RDATA : PTR;
          if (state == ADDR_ACK && rw) begin
            shreg_d  = rd_byte;
            sda_oe_d = ~rd_byte[7];
          end
        end
        RDATA: if (last) begin
          state_d   = RDATA_ACK;
          sda_oe_d  = 1'b0;
          bit_cnt_d = '0;
        end else begin
          shreg_d   = {shreg[6:0], 1'b0};
          sda_oe_d  = ~shreg[6];
          bit_cnt_d = bit_cnt + 3'd1;
        end
        RDATA_ACK: begin
          state_d   = RDATA;
          shreg_d   = rd_byte;
          sda_oe_d  = ~rd_byte[7];
          bit_cnt_d = '0;
        end
        IGNORE: sda_oe_d = 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_target_responder.sv
// tb_i2c_target_responder: bit-banged I2C master against a pointer/register-array reference model.
module tb_i2c_target_responder;
  localparam int Q = 6;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl = 1'b1;
  logic sda_m = 1'b1;
  logic [63:0] regs = '0;
  logic sda_line, sda_oe, wr_valid, busy, rx_nack;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  int total = 0, bad = 0, nack_cnt = 0;
  bit oe_seen, busy_seen;
  logic [10:0] wq[$];
  int mptr = 0;
  int mai = 0;
  logic [7:0] wbytes [4];
  assign sda_line = sda_m & ~sda_oe;
  always #5 clk = ~clk;
  i2c_target_responder dut (
    .FSM_Clk(clk), .reset(reset), .scl_in(scl), .sda_in(sda_line), .sda_oe(sda_oe),
    .reg_data(regs), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .rx_nack(rx_nack)
  );
  always @(negedge clk) if (!reset) begin
    if (wr_valid) wq.push_back({wr_addr, wr_data});
    if (rx_nack) nack_cnt++;
    if (sda_oe) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
  end
  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] mreg(input int i);
    return regs[i*8 +: 8];
  endfunction
  task automatic half();
    repeat (Q) @(negedge clk);
  endtask
  task automatic start_c();
    sda_m = 1'b1; half(); scl = 1'b1; half(); sda_m = 1'b0; half(); scl = 1'b0; half();
  endtask
  task automatic stop_c();
    sda_m = 1'b0; half(); scl = 1'b1; half(); sda_m = 1'b1; half();
  endtask
  task automatic clock_bit(input logic b, output logic r);
    sda_m = b; half(); scl = 1'b1; half();
    r = sda_line;
    half(); scl = 1'b0; half();
  endtask
  task automatic send(input logic [7:0] b, input string tag, input logic exp_ack);
    logic r;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
    clock_bit(1'b1, r);
    check(tag, r, exp_ack);
  endtask
  task automatic recv(input logic ack, output logic [7:0] d);
    logic r;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, r);
      d = {d[6:0], r};
    end
    clock_bit(ack, r);
  endtask
  task automatic write_txn(input logic [7:0] p, input int n);
    logic [10:0] eq[$];
    wq.delete();
    start_c();
    send(8'h90, "wr addr ack", 1'b0);
    send(p, "wr ptr ack", 1'b0);
    mptr = int'(p[2:0]);
    mai = int'(p[7]);
    for (int i = 0; i < n; i++) begin
      send(wbytes[i], "wr data ack", 1'b0);
      eq.push_back({3'(mptr), wbytes[i]});
      mptr = (mptr + mai) % 8;
    end
    stop_c();
    check("wr count", wq.size(), eq.size());
    while (eq.size() > 0 && wq.size() > 0) check("wr entry", wq.pop_front(), eq.pop_front());
    check("wr busy after stop", busy, 1'b0);
  endtask
  task automatic read_txn(input bit set_ptr, input logic [7:0] p, input int n);
    logic [7:0] got;
    int n0;
    wq.delete();
    start_c();
    if (set_ptr) begin
      send(8'h90, "rd waddr ack", 1'b0);
      send(p, "rd ptr ack", 1'b0);
      mptr = int'(p[2:0]);
      mai = int'(p[7]);
      start_c();
    end
    send(8'h91, "rd raddr ack", 1'b0);
    n0 = nack_cnt;
    for (int i = 0; i < n; i++) begin
      recv(i == n - 1, got);
      check("rd byte", got, mreg(mptr));
      if (i < n - 1) mptr = (mptr + mai) % 8;
    end
    half();
    check("rd oe after nack", sda_oe, 1'b0);
    check("rd nack pulses", nack_cnt - n0, 1);
    stop_c();
    check("rd no write", wq.size(), 0);
    check("rd busy after stop", busy, 1'b0);
  endtask
  task automatic mismatch_txn(input logic [7:0] a);
    wq.delete();
    oe_seen = 1'b0;
    busy_seen = 1'b0;
    start_c();
    send(a, "na addr ack", 1'b1);
    send(8'($urandom), "na data ack", 1'b1);
    stop_c();
    check("na oe seen", oe_seen, 1'b0);
    check("na busy seen", busy_seen, 1'b0);
    check("na no write", wq.size(), 0);
  endtask
  initial begin
    logic [6:0] a;
    repeat (4) @(negedge clk);
    check("rst sda_oe", sda_oe, 1'b0);
    check("rst wr_valid", wr_valid, 1'b0);
    check("rst wr_addr", wr_addr, 3'd0);
    check("rst wr_data", wr_data, 8'd0);
    check("rst busy", busy, 1'b0);
    check("rst rx_nack", rx_nack, 1'b0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    wbytes[0] = 8'hA5;
    wbytes[1] = 8'h3C;
    write_txn(8'h82, 2);
    regs = {$urandom, $urandom};
    regs[15:0] = 16'h3412;
    read_txn(1'b1, 8'h80, 2);
    mismatch_txn(8'h92);
    regs = {$urandom, $urandom};
    read_txn(1'b1, 8'h87, 3);
    read_txn(1'b1, 8'h05, 2);
    regs = {$urandom, $urandom};
    regs[7:0] = 8'h00;
    write_txn(8'h00, 0);
    start_c();
    send(8'h91, "mid addr ack", 1'b0);
    begin
      logic r;
      repeat (3) clock_bit(1'b1, r);
    end
    for (int i = 0; i < 20 && !sda_oe; i++) @(negedge clk);
    check("mid oe bit4", sda_oe, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("mid oe after reset", sda_oe, 1'b0);
    reset = 1'b0;
    mptr = 0;
    mai = 0;
    regs[7:0] = 8'($urandom);
    read_txn(1'b0, 8'h00, 1);
    for (int k = 0; k < 14; k++) begin
      regs = {$urandom, $urandom};
      case ($urandom_range(0, 2))
        0: begin
          for (int i = 0; i < 4; i++) wbytes[i] = 8'($urandom);
          write_txn(8'($urandom), $urandom_range(1, 3));
        end
        1: read_txn(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(1, 4));
        default: begin
          a = 7'($urandom_range(0, 127));
          if (a == 7'h48) a = 7'h49;
          mismatch_txn({a, 1'($urandom_range(0, 1))});
        end
      endcase
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i2c_target_responder.md
Name: i2c_target_responder

Overview:
- I2C target (slave) that emulates a register-mapped sensor on the same SCL/SDA bus driven by the team's I2C master FSMs.
- Lets the master read paths (address/W, register pointer, repeated start, address/R, multi-byte read with master ACK/NACK, stop) run against RTL in simulation and on the board without a physical sensor.
- Register contents are supplied in parallel by a host-side port. Master writes are reported on a strobe port.

Parameters:
- DEV_ADDR, 7'b100_1000, 7-bit target address. The 8-bit frames are 8'h90 for write and 8'h91 for read.
- NUM_REGS, 8, number of byte registers. Must be a power of 2, 2 to 128.
- AUTOINC_BIT, 7, bit of the pointer byte that enables auto-increment. The remaining low bits are the pointer.

Ports:
- FSM_Clk  in  1  system clock. Must be at least 8x the SCL frequency.
- reset  in  1  synchronous, active-high reset.
- scl_in  in  1  raw SCL from the pad. Asynchronous.
- sda_in  in  1  raw SDA from the pad. Asynchronous.
- sda_oe  out  1  1 = pull SDA low. Open-drain: the block never drives SDA high.
- reg_data  in  8*NUM_REGS  register image. Byte k is reg_data[8k+7:8k].
- wr_valid  out  1  one-cycle strobe when a master-written data byte is accepted.
- wr_addr  out  log2(NUM_REGS)  register index of the written byte.
- wr_data  out  8  written byte.
- busy  out  1  high from an addressed START until STOP or mismatch.
- rx_nack  out  1  one-cycle pulse when the master NACKs a read byte.

Behaviour:
- Input synchronisation:
  - scl_in and sda_in each pass through a 2-flop synchroniser, then a 1-flop history for edge detection.
  - Edges act 3 FSM_Clk cycles after the pin transition.
- Bus events, evaluated every cycle. Priority: START/STOP over SCL edges.
  - START: synchronised SDA falls while SCL is high.
  - STOP: synchronised SDA rises while SCL is high.
  - SCL rise: sample SDA.
  - SCL fall: update sda_oe.
- Reset values: sda_oe=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, rx_nack=0, state IDLE, pointer=0, autoinc=0, bit counter=0.
- Reset mid-transfer: on the first cycle with reset high, the next edge releases SDA (sda_oe=0) and forces IDLE. Bus activity is ignored until the next START.
- States:
  - IDLE: wait for START, then go to ADDR with bit count 0.
  - ADDR: shift 8 bits, MSB first, on SCL rises.
    - After bit 8: if [7:1]==DEV_ADDR, go to ADDR_ACK, set busy, and latch rw=[0].
    - Otherwise go to IGNORE.
  - ADDR_ACK:
    - On the SCL fall after bit 8, sda_oe=1.
    - On the next SCL fall, go to RDATA if rw=1, or to PTR if rw=0.
    - For RDATA: load the shift register with byte[pointer] and drive its MSB (sda_oe = ~bit) on that same fall.
  - PTR: shift 8 bits. pointer = byte[log2(NUM_REGS)-1:0] mod NUM_REGS; autoinc = byte[AUTOINC_BIT]. Then go to PTR_ACK.
  - PTR_ACK: ACK timing as in ADDR_ACK, then go to WDATA.
  - WDATA: shift 8 bits, then go to WDATA_ACK.
    - At the 8th SCL rise, pulse wr_valid with wr_addr=pointer and wr_data=byte.
    - Increment pointer if autoinc. Pointer wraps NUM_REGS-1 -> 0.
  - WDATA_ACK: ACK, then go back to WDATA.
  - RDATA: present bits 6..0 on successive SCL falls. On the SCL fall after bit 0, release SDA and go to RDATA_ACK.
  - RDATA_ACK: sample SDA at the SCL rise.
    - 0 (ACK): pointer += autoinc, with wrap. On the next SCL fall, load the new byte and drive its MSB, then go to RDATA.
    - 1 (NACK): pulse rx_nack and go to IGNORE with SDA released. The pointer is not advanced.
  - IGNORE: sda_oe=0. Wait for START (go to ADDR) or STOP (go to IDLE).
- START in any state, including mid-byte (repeated start): go to ADDR, sda_oe=0, bit count cleared. pointer and autoinc are retained.
- STOP in any state: go to IDLE, sda_oe=0, busy=0. A partial byte is discarded and causes no wr_valid.
- reg_data is sampled only at byte-load instants. Changes mid-byte do not affect the byte in flight.

Test Plan:
- Write transaction: START, 0x90, ptr 0x82, data 0xA5 then 0x3C, STOP -> ACK low on all 4 ninth clocks; wr_valid pulses twice, first (2, 0xA5) then (3, 0x3C); busy 0 after STOP.
- Combined read: reg_data bytes 0..1 = 0x12, 0x34. Master sends START, 0x90, ptr 0x80, repeated START, 0x91, ACKs byte 1, NACKs byte 2, STOP -> SDA shows 0x12 then 0x34; rx_nack pulses once; sda_oe=0 after the NACK.
- Address mismatch: START, 0x92 ... STOP -> sda_oe stays 0 for the whole frame; no wr_valid; busy stays 0.
- Pointer wrap: ptr 0x87, read 3 bytes with ACK, ACK, NACK -> bytes 7, 0, 1 returned in order.
- Auto-increment off: ptr 0x05, read 2 bytes -> byte 5 returned twice.
- Reset mid-read: assert reset during bit 4 of RDATA while sda_oe=1 -> sda_oe=0 the next cycle; following frame with START, 0x91 -> normal ACK and byte[0].
